// File: rtl/radix5_stage_seq.sv
// radix5_stage_seq
//   Sequencer around an external fixed-latency, non-stallable radix-5
//   butterfly. It gathers five serial complex samples (lanes a..e), issues
//   them to the datapath with a one-cycle strobe, follows each group through
//   the datapath latency, catches the result in a two-slot ping-pong buffer
//   and plays the buffer out as a serial valid/ready stream. An issue only
//   happens when the groups in flight plus the full slots leave a free slot,
//   so the buffer cannot overflow.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_valid/s_ready/s_re/s_img  serial sample input
//   dp_issue, dp_re, dp_img     group issued to the datapath (lane k at [k*DW +: DW])
//   dp_out_re, dp_out_img       datapath result, valid LAT cycles after issue
//   m_valid/m_ready/m_re/m_img  serial result output
//   m_last                      last output sample of a frame of NBFLY groups
//   frame_done                  one-cycle pulse after the m_last handshake
//   busy                        data is held somewhere in the block
//
// Input FSM states
//   state     | meaning
//   ST_GATHER | accepting samples into lane[count]
//   ST_FULL   | five lanes held, waiting for output credit; issues on credit
module radix5_stage_seq #(
   parameter int DW    = 32,
   parameter int LAT   = 9,
   parameter int NBFLY = 25
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_re,
   input  logic [DW-1:0]   s_img,
   output logic            dp_issue,
   output logic [5*DW-1:0] dp_re,
   output logic [5*DW-1:0] dp_img,
   input  logic [5*DW-1:0] dp_out_re,
   input  logic [5*DW-1:0] dp_out_img,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_re,
   output logic [DW-1:0]   m_img,
   output logic            m_last,
   output logic            frame_done,
   output logic            busy
);

   localparam int GW = (NBFLY > 1) ? $clog2(NBFLY) : 1;
   localparam logic [GW-1:0] GRP_LAST = GW'(NBFLY - 1);

   typedef enum logic {ST_GATHER = 1'b0, ST_FULL = 1'b1} state_t;

   state_t          state;
   logic [2:0]      count;
   logic [5*DW-1:0] gat_re, gat_img;
   logic [LAT:0]    iss_sr;
   logic [1:0]      inflight;
   logic [1:0]      occ;
   logic [1:0]      slot_full;
   logic [5*DW-1:0] slot_re  [2];
   logic [5*DW-1:0] slot_img [2];
   logic            wsel, rsel;
   logic [2:0]      idx;
   logic [GW-1:0]   grp;

   logic accept, credit, issue_now, capture, handshake, last_beat;

   // Credit uses registered occupancy only: a slot freed by this cycle's
   // handshake is seen by the FSM one cycle later.
   always_comb begin
      occ       = {1'b0, slot_full[0]} + {1'b0, slot_full[1]};
      credit    = ({1'b0, occ} + {1'b0, inflight}) < 3'd2;
      issue_now = (state == ST_FULL) && credit;
      accept    = s_valid && (state == ST_GATHER);
      capture   = iss_sr[LAT];
      last_beat = (idx == 3'd4);
      handshake = m_valid && m_ready;
   end

   assign s_ready = (state == ST_GATHER);
   assign m_valid = slot_full[rsel];
   assign m_re    = slot_re[rsel][int'(idx)*DW +: DW];
   assign m_img   = slot_img[rsel][int'(idx)*DW +: DW];
   assign m_last  = m_valid && last_beat && (grp == GRP_LAST);
   assign busy    = (state != ST_GATHER) || (count != 3'd0) ||
                    (inflight != 2'd0) || (occ != 2'd0);

   // Input side: gather, issue, and track groups through the datapath.
   // iss_sr[k] marks a group issued k cycles ago; bit LAT is the capture cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_GATHER;
         count    <= 3'd0;
         gat_re   <= '0;
         gat_img  <= '0;
         dp_issue <= 1'b0;
         dp_re    <= '0;
         dp_img   <= '0;
         iss_sr   <= '0;
         inflight <= 2'd0;
      end else begin
         dp_issue <= 1'b0;
         iss_sr   <= {iss_sr[LAT-1:0], issue_now};
         case ({issue_now, capture})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: ;
         endcase
         case (state)
            ST_GATHER: begin
               if (accept) begin
                  gat_re[int'(count)*DW +: DW]  <= s_re;
                  gat_img[int'(count)*DW +: DW] <= s_img;
                  if (count == 3'd4) begin
                     count <= 3'd0;
                     state <= ST_FULL;
                  end else begin
                     count <= count + 3'd1;
                  end
               end
            end
            ST_FULL: begin
               if (credit) begin
                  dp_issue <= 1'b1;
                  dp_re    <= gat_re;
                  dp_img   <= gat_img;
                  state    <= ST_GATHER;
               end
            end
            default: state <= ST_GATHER;
         endcase
      end
   end

   // Output side: ping-pong capture and serial playout. Credit guarantees
   // a capture never targets the slot being freed in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            slot_re[i]  <= '0;
            slot_img[i] <= '0;
         end
         slot_full  <= 2'b00;
         wsel       <= 1'b0;
         rsel       <= 1'b0;
         idx        <= 3'd0;
         grp        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= handshake && m_last;
         if (capture) begin
            slot_re[wsel]   <= dp_out_re;
            slot_img[wsel]  <= dp_out_img;
            slot_full[wsel] <= 1'b1;
            wsel            <= ~wsel;
         end
         if (handshake) begin
            if (last_beat) begin
               slot_full[rsel] <= 1'b0;
               rsel            <= ~rsel;
               idx             <= 3'd0;
               grp             <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_radix5_stage_seq.sv
// tb_radix5_stage_seq
//   Bench for radix5_stage_seq with an identity datapath model (the issued
//   group reappears exactly LAT cycles later, random junk otherwise) and an
//   order-preserving scoreboard: every accepted sample must come out in
//   input order, with m_last on every (5*NBFLY)-th output sample.
module tb_radix5_stage_seq;

   localparam int DW    = 32;
   localparam int LAT   = 9;
   localparam int NBFLY = 25;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [DW-1:0]   s_re = '0;
   logic [DW-1:0]   s_img = '0;
   logic            dp_issue;
   logic [5*DW-1:0] dp_re, dp_img;
   logic [5*DW-1:0] dp_out_re = '0;
   logic [5*DW-1:0] dp_out_img = '0;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic [DW-1:0]   m_re, m_img;
   logic            m_last;
   logic            frame_done;
   logic            busy;

   int vectors = 0;
   int miscompares = 0;
   int unsigned cyc = 0;

   radix5_stage_seq #(.DW(DW), .LAT(LAT), .NBFLY(NBFLY)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_img(s_img),
      .dp_issue(dp_issue), .dp_re(dp_re), .dp_img(dp_img),
      .dp_out_re(dp_out_re), .dp_out_img(dp_out_img),
      .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_img(m_img),
      .m_last(m_last), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Identity datapath, not reset: a squashed group still comes back.
   int unsigned     dp_due [$];
   logic [5*DW-1:0] dp_q_re [$];
   logic [5*DW-1:0] dp_q_img [$];
   always begin
      @(posedge clk);
      #1;
      if (dp_issue) begin
         dp_due.push_back(cyc + LAT);
         dp_q_re.push_back(dp_re);
         dp_q_img.push_back(dp_img);
      end
      if (dp_due.size() > 0 && dp_due[0] == cyc) begin
         dp_out_re  = dp_q_re.pop_front();
         dp_out_img = dp_q_img.pop_front();
         void'(dp_due.pop_front());
      end else begin
         dp_out_re  = {$urandom, $urandom, $urandom, $urandom, $urandom};
         dp_out_img = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
   end

   // Scoreboard
   logic [DW-1:0] exp_re [$];
   logic [DW-1:0] exp_img [$];
   int            out_n = 0;
   int            last_seen = 0;
   int            fd_seen = 0;
   int            stall_seen = 0;
   logic          prev_stall = 1'b0;
   logic          prev_last_hs = 1'b0;
   logic [DW-1:0] prev_re = '0, prev_img = '0;

   always @(negedge clk) begin
      logic [DW-1:0] er, ei;
      logic          exp_last;
      if (!rst_n) begin
         exp_re.delete();
         exp_img.delete();
         out_n        = 0;
         last_seen    = 0;
         fd_seen      = 0;
         prev_stall   = 1'b0;
         prev_last_hs = 1'b0;
      end else begin
         if (s_valid && s_ready) begin
            exp_re.push_back(s_re);
            exp_img.push_back(s_img);
         end
         vectors++;
         if (frame_done !== prev_last_hs) begin
            miscompares++;
            $display("FAIL frame_done @%0d: got %0b want %0b", cyc, frame_done, prev_last_hs);
         end
         if (frame_done) fd_seen++;
         if (prev_stall) begin
            vectors++;
            if (m_valid !== 1'b1 || m_re !== prev_re || m_img !== prev_img) begin
               miscompares++;
               $display("FAIL stall_hold @%0d: got v=%0b %0h/%0h want v=1 %0h/%0h",
                        cyc, m_valid, m_re, m_img, prev_re, prev_img);
            end
         end
         exp_last = 1'b0;
         if (m_valid && m_ready) begin
            vectors++;
            if (exp_re.size() == 0) begin
               miscompares++;
               $display("FAIL out_extra @%0d: got %0h/%0h want no output", cyc, m_re, m_img);
            end else begin
               er = exp_re.pop_front();
               ei = exp_img.pop_front();
               if (m_re !== er || m_img !== ei) begin
                  miscompares++;
                  $display("FAIL out_data #%0d: got %0h/%0h want %0h/%0h", out_n, m_re, m_img, er, ei);
               end
            end
            exp_last = ((out_n + 1) % (5 * NBFLY)) == 0;
            vectors++;
            if (m_last !== exp_last) begin
               miscompares++;
               $display("FAIL m_last #%0d: got %0b want %0b", out_n, m_last, exp_last);
            end
            if (m_last) last_seen++;
            out_n++;
         end
         prev_last_hs = exp_last;
         prev_stall   = m_valid && !m_ready;
         if (prev_stall) stall_seen++;
         prev_re  = m_re;
         prev_img = m_img;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_re    = '0;
      s_img   = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Holds one sample on the input until accepted (bounded).
   task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      s_valid = 1'b1;
      s_re    = re;
      s_img   = im;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({dp_issue, m_valid, m_last, frame_done, busy, s_ready} !== 6'b000001) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000001",
                  {dp_issue, m_valid, m_last, frame_done, busy, s_ready});
      end
      vectors++;
      if (dp_re !== '0 || dp_img !== '0 || m_re !== '0 || m_img !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got dp=%0h/%0h m=%0h/%0h want all 0", dp_re, dp_img, m_re, m_img);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit              ok;
      logic [5*DW-1:0] lanes;
      apply_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(DW'(i), '0, ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL basic_accept: sample %0d got timeout want accepted", i);
         end
      end
      s_valid = 1'b0;
      vectors++;
      if (dp_issue !== 1'b0 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_full: got issue=%0b ready=%0b want 0 0", dp_issue, s_ready);
      end
      tick();
      lanes = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      vectors++;
      if (dp_issue !== 1'b1 || dp_re !== lanes || dp_img !== '0) begin
         miscompares++;
         $display("FAIL basic_issue: got issue=%0b re=%0h img=%0h want 1 %0h 0", dp_issue, dp_re, dp_img, lanes);
      end
      for (int k = 1; k <= 15; k++) begin
         tick();
         vectors++;
         if (m_valid !== (k >= 10 && k <= 14)) begin
            miscompares++;
            $display("FAIL basic_mvalid: issue+%0d got %0b want %0b", k, m_valid, (k >= 10 && k <= 14));
         end
         if (k >= 10 && k <= 14) begin
            vectors++;
            if (m_re !== DW'(k - 9) || m_img !== '0) begin
               miscompares++;
               $display("FAIL basic_mdata: issue+%0d got %0h/%0h want %0h/0", k, m_re, m_img, k - 9);
            end
         end
         if (k == 1) begin
            vectors++;
            if (dp_issue !== 1'b0 || dp_re !== lanes) begin
               miscompares++;
               $display("FAIL basic_hold: got issue=%0b re=%0h want 0 %0h", dp_issue, dp_re, lanes);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int  sent;
      bit  acc;
      sent = 0;
      apply_reset();
      m_ready = 1'b0;
      for (int c = 0; c < 60; c++) begin
         s_valid = (sent < 25);
         if (c == 0 || acc) begin
            s_re  = $urandom;
            s_img = $urandom;
         end
         @(negedge clk);
         acc = s_valid && s_ready;
         tick();
         if (acc) sent++;
      end
      vectors++;
      if (sent !== 15 || s_ready !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_stall: got sent=%0d ready=%0b busy=%0b mv=%0b want 15 0 1 1",
                  sent, s_ready, busy, m_valid);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 500 && (sent < 25 || out_n < 25); c++) begin
         s_valid = (sent < 25);
         if (acc) begin
            s_re  = $urandom;
            s_img = $urandom;
         end
         @(negedge clk);
         acc = s_valid && s_ready;
         tick();
         if (acc) sent++;
      end
      s_valid = 1'b0;
      vectors++;
      if (out_n !== 25 || exp_re.size() !== 0) begin
         miscompares++;
         $display("FAIL bp_drain: got out=%0d left=%0d want 25 0", out_n, exp_re.size());
      end
   endtask

   task automatic test_frame();
      bit ok;
      apply_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 250; i++) begin
         send($urandom, $urandom, ok);
         if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_accept: sample %0d got timeout want accepted", i);
            break;
         end
      end
      s_valid = 1'b0;
      for (int c = 0; c < 100 && out_n < 250; c++) tick();
      repeat (2) tick();
      vectors++;
      if (out_n !== 250 || last_seen !== 2 || fd_seen !== 2) begin
         miscompares++;
         $display("FAIL frame_counts: got out=%0d last=%0d done=%0d want 250 2 2", out_n, last_seen, fd_seen);
      end
   endtask

   task automatic test_stall_toggle();
      bit ok;
      int stalls0;
      apply_reset();
      stalls0 = stall_seen;
      fork
         begin
            for (int c = 0; c < 400; c++) begin
               m_ready = ~m_ready;
               tick();
            end
            m_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 20; i++) begin
               send($urandom, $urandom, ok);
               if (!ok) break;
            end
            s_valid = 1'b0;
         end
      join
      repeat (4) tick();
      vectors++;
      if (out_n !== 20 || exp_re.size() !== 0 || stall_seen == stalls0) begin
         miscompares++;
         $display("FAIL toggle_drain: got out=%0d left=%0d stalls=%0d want 20 0 >0",
                  out_n, exp_re.size(), stall_seen - stalls0);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      apply_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) send($urandom, $urandom, ok);
      s_valid = 1'b0;
      n = 0;
      while (dp_issue !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (dp_issue !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_issue: got no issue want issue within 20 cycles");
      end
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({dp_issue, m_valid, m_last, frame_done, busy, s_ready} !== 6'b000001 ||
          dp_re !== '0 || m_re !== '0) begin
         miscompares++;
         $display("FAIL rmid_async: got flags=%b dp_re=%0h m_re=%0h want 000001 0 0",
                  {dp_issue, m_valid, m_last, frame_done, busy, s_ready}, dp_re, m_re);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         vectors++;
         if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_ignore: +%0d got mv=%0b rdy=%0b busy=%0b want 0 1 0",
                     k, m_valid, s_ready, busy);
         end
      end
   endtask

   task automatic test_credit_release();
      bit ok;
      apply_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 15; i++) send($urandom, $urandom, ok);
      s_valid = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick();
         vectors++;
         if (dp_issue !== 1'b0) begin
            miscompares++;
            $display("FAIL credit_hold: +%0d got issue=1 want 0", k);
         end
      end
      m_ready = 1'b1;
      // Five handshakes drain slot rsel; the fifth happens in cycle h.
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (dp_issue !== 1'b0 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_drain: beat %0d got issue=%0b mv=%0b want 0 1", k, dp_issue, m_valid);
         end
         if (k < 4) tick();
      end
      tick();
      m_ready = 1'b0;
      // h+1: slot flag has cleared, FSM sees credit now; strobe follows.
      vectors++;
      if (dp_issue !== 1'b0 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL credit_early: got issue=%0b ready=%0b want 0 0", dp_issue, s_ready);
      end
      tick();
      vectors++;
      if (dp_issue !== 1'b1) begin
         miscompares++;
         $display("FAIL credit_issue: got issue=%0b want 1", dp_issue);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 100 && out_n < 15; c++) tick();
      vectors++;
      if (out_n !== 15 || exp_re.size() !== 0) begin
         miscompares++;
         $display("FAIL credit_drain_all: got out=%0d left=%0d want 15 0", out_n, exp_re.size());
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_frame();
      test_stall_toggle();
      test_reset_mid();
      test_credit_release();
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
